// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-to-execute operand bundle and execute-to-memory result bundle
interface execute_stage_if;
  logic [3:0] de_aluop;
  logic [31:0] de_alusrc1, de_alusrc2;
  logic [32:0] de_extend_rs, de_extend_rt;
  logic de_mem_en;
  logic [3:0] de_mem_wen;
  logic [31:0] de_mem_wdata;
  logic de_mem_read, de_reg_en;
  logic [5:0] de_reg_waddr;
  logic de_double_en, de_mul, de_div;
  logic [31:0] exe_result, exe_hi, exe_lo;
  logic exe_mem_en;
  logic [3:0] exe_mem_wen;
  logic [31:0] exe_mem_wdata;
  logic exe_mem_read, exe_reg_en;
  logic [5:0] exe_reg_waddr;
  logic exe_double_en, exe_stall;
  modport master (
    output de_aluop, de_alusrc1, de_alusrc2, de_extend_rs, de_extend_rt, de_mem_en, de_mem_wen,
           de_mem_wdata, de_mem_read, de_reg_en, de_reg_waddr, de_double_en, de_mul, de_div,
    input  exe_result, exe_hi, exe_lo, exe_mem_en, exe_mem_wen, exe_mem_wdata, exe_mem_read,
           exe_reg_en, exe_reg_waddr, exe_double_en, exe_stall
  );
  modport slave (
    input  de_aluop, de_alusrc1, de_alusrc2, de_extend_rs, de_extend_rt, de_mem_en, de_mem_wen,
           de_mem_wdata, de_mem_read, de_reg_en, de_reg_waddr, de_double_en, de_mul, de_div,
    output exe_result, exe_hi, exe_lo, exe_mem_en, exe_mem_wen, exe_mem_wdata, exe_mem_read,
           exe_reg_en, exe_reg_waddr, exe_double_en, exe_stall
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with ALU, 33x33 signed multiplier and optional
// 32-cycle restoring divider (built only when EXE_DIV_EN is defined).
module execute_stage (
  input logic clk,
  input logic resetn,
  execute_stage_if.slave bus
);
  logic [31:0] a, b, alu;
  logic [63:0] prod;
  logic div_ok, stall;
  logic [31:0] div_q, div_r;
  assign a = bus.de_alusrc1;
  assign b = bus.de_alusrc2;
  always_comb begin
    case (bus.de_aluop)
      4'd0: alu = a & b;
      4'd1: alu = a | b;
      4'd2: alu = a + b;
      4'd3: alu = a - b;
      4'd4: alu = {31'd0, $signed(a) < $signed(b)};
      4'd5: alu = {31'd0, a < b};
      4'd6, 4'd8: alu = b << a[4:0];
      4'd7: alu = b >> a[4:0];
      4'd9: alu = $signed(b) >>> a[4:0];
      4'd10: alu = {b[15:0], 16'h0};
      4'd11: alu = a ^ b;
      4'd12: alu = ~(a | b);
      default: alu = '0;
    endcase
  end
  // low 64 bits of the 66-bit signed product; operands pre-extended so the multiply is 64-bit
  assign prod = {{31{bus.de_extend_rs[32]}}, bus.de_extend_rs} * {{31{bus.de_extend_rt[32]}}, bus.de_extend_rt};
`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;
  st_t st, st_n;
  logic [5:0] cnt;
  logic [31:0] q, r, dv, ma, mb;
  logic [32:0] t;
  logic qs, rsg, ge;
  assign ma = bus.de_extend_rs[32] ? -bus.de_extend_rs[31:0] : bus.de_extend_rs[31:0];
  assign mb = bus.de_extend_rt[32] ? -bus.de_extend_rt[31:0] : bus.de_extend_rt[31:0];
  assign t = {r, q[31]};
  assign ge = t >= {1'b0, dv};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = (st == IDLE && bus.de_div) ? BUSY :
           (st == BUSY && cnt == 6'd31) ? DONE :
           (st == DONE) ? IDLE : st;
  end
  always_comb begin
    stall = resetn & ((st == IDLE & bus.de_div) | (st == BUSY));
    div_ok = st == DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {cnt, q, r, dv, qs, rsg} <= '0;
    end else if (st == IDLE && bus.de_div) begin
      q <= ma;
      r <= '0;
      dv <= mb;
      cnt <= '0;
      qs <= bus.de_extend_rs[32] ^ bus.de_extend_rt[32];
      rsg <= bus.de_extend_rs[32];
    end else if (st == BUSY) begin
      q <= {q[30:0], ge};
      r <= ge ? t[31:0] - dv : t[31:0];
      cnt <= cnt + 6'd1;
    end
  end
  // decode holds its operands through DONE, so the raw dividend is still on the bus
  assign div_q = dv == '0 ? '1 : qs ? -q : q;
  assign div_r = dv == '0 ? bus.de_extend_rs[31:0] : rsg ? -r : r;
`else
  assign stall = 1'b0;
  assign div_ok = bus.de_div;
  assign div_q = '0;
  assign div_r = '0;
`endif
  assign bus.exe_stall = stall;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {bus.exe_result, bus.exe_hi, bus.exe_lo, bus.exe_mem_wdata} <= '0;
      {bus.exe_mem_en, bus.exe_mem_wen, bus.exe_mem_read, bus.exe_reg_en} <= '0;
      {bus.exe_reg_waddr, bus.exe_double_en} <= '0;
    end else begin
      bus.exe_mem_en <= !stall & bus.de_mem_en;
      bus.exe_mem_wen <= stall ? 4'd0 : bus.de_mem_wen;
      bus.exe_mem_read <= !stall & bus.de_mem_read;
      bus.exe_reg_en <= !stall & bus.de_reg_en;
      bus.exe_double_en <= !stall & (div_ok | bus.de_double_en);
      if (!stall) begin
        bus.exe_result <= alu;
        bus.exe_mem_wdata <= bus.de_mem_wdata;
        bus.exe_reg_waddr <= bus.de_reg_waddr;
        if (div_ok) {bus.exe_hi, bus.exe_lo} <= {div_r, div_q};
        else if (bus.de_mul) {bus.exe_hi, bus.exe_lo} <= prod;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage (divider tests need EXE_DIV_EN)
module tb_execute_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                     input logic [31:0] exp, input string tag);
    bus.de_aluop = op;
    bus.de_alusrc1 = s1;
    bus.de_alusrc2 = s2;
    step();
    chk(tag, bus.exe_result, exp);
  endtask
`ifdef EXE_DIV_EN
  task automatic run_div(input string tag, input logic [32:0] rs, input logic [32:0] rt,
                         input logic [31:0] elo, input logic [31:0] ehi);
    int n = 0;
    bus.de_extend_rs = rs;
    bus.de_extend_rt = rt;
    bus.de_div = 1'b1;
    bus.de_reg_en = 1'b1;
    bus.de_mem_en = 1'b1;
    #1;
    while (bus.exe_stall === 1'b1 && n < 60) begin
      step();
      n++;
      if (n == 5) begin
        chk({tag, "_bubble_reg_en"}, bus.exe_reg_en, 0);
        chk({tag, "_bubble_mem_en"}, bus.exe_mem_en, 0);
        chk({tag, "_bubble_double_en"}, bus.exe_double_en, 0);
      end
    end
    chk({tag, "_stall_cycles"}, n, 33);
    step();
    chk({tag, "_lo"}, bus.exe_lo, elo);
    chk({tag, "_hi"}, bus.exe_hi, ehi);
    chk({tag, "_double_en"}, bus.exe_double_en, 1);
    bus.de_div = 1'b0;
  endtask
`endif
  initial begin
    bus.de_aluop = '0;
    bus.de_alusrc1 = '0;
    bus.de_alusrc2 = '0;
    bus.de_extend_rs = '0;
    bus.de_extend_rt = '0;
    bus.de_mem_en = 1'b0;
    bus.de_mem_wen = '0;
    bus.de_mem_wdata = '0;
    bus.de_mem_read = 1'b0;
    bus.de_reg_en = 1'b0;
    bus.de_reg_waddr = '0;
    bus.de_double_en = 1'b0;
    bus.de_mul = 1'b0;
    bus.de_div = 1'b0;
    step();
    step();
    chk("rst_result", bus.exe_result, 0);
    chk("rst_hi", bus.exe_hi, 0);
    chk("rst_lo", bus.exe_lo, 0);
    chk("rst_reg_en", bus.exe_reg_en, 0);
    chk("rst_double_en", bus.exe_double_en, 0);
    chk("rst_stall", bus.exe_stall, 0);
    resetn = 1'b1;
    bus.de_reg_en = 1'b1;
    bus.de_reg_waddr = 6'd5;
    bus.de_mem_en = 1'b1;
    bus.de_mem_wen = 4'hF;
    bus.de_mem_wdata = 32'hDEADBEEF;
    bus.de_mem_read = 1'b1;
    alu(4'd2, 32'h7FFFFFFF, 32'h1, 32'h80000000, "add_wrap");
    chk("pt_reg_en", bus.exe_reg_en, 1);
    chk("pt_reg_waddr", bus.exe_reg_waddr, 5);
    chk("pt_mem_en", bus.exe_mem_en, 1);
    chk("pt_mem_wen", bus.exe_mem_wen, 4'hF);
    chk("pt_mem_wdata", bus.exe_mem_wdata, 32'hDEADBEEF);
    chk("pt_mem_read", bus.exe_mem_read, 1);
    bus.de_mem_wen = 4'h0;
    bus.de_mem_read = 1'b0;
    alu(4'd3, 32'h0, 32'h1, 32'hFFFFFFFF, "sub_wrap");
    chk("pt_mem_wen0", bus.exe_mem_wen, 0);
    alu(4'd0, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, "and");
    alu(4'd1, 32'hF0000000, 32'h0000000F, 32'hF000000F, "or");
    alu(4'd4, 32'hFFFFFFFF, 32'h1, 32'h1, "slt_neg");
    alu(4'd5, 32'hFFFFFFFF, 32'h1, 32'h0, "sltu");
    alu(4'd6, 32'h24, 32'h1, 32'h10, "sll_amt5");
    alu(4'd8, 32'h4, 32'h3, 32'h30, "sal");
    alu(4'd7, 32'h4, 32'h80000000, 32'h08000000, "srl");
    alu(4'd9, 32'h4, 32'h80000000, 32'hF8000000, "sra");
    alu(4'd10, 32'h0, 32'hFFFF1234, 32'h12340000, "lui");
    alu(4'd11, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, "xor");
    alu(4'd12, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, "nor");
    alu(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, "op13");
    bus.de_mul = 1'b1;
    bus.de_double_en = 1'b1;
    bus.de_extend_rs = 33'h1FFFFFFFF;
    bus.de_extend_rt = 33'h000000002;
    step();
    chk("mult_hi", bus.exe_hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.exe_lo, 32'hFFFFFFFE);
    chk("mult_double_en", bus.exe_double_en, 1);
    bus.de_extend_rs = 33'h0FFFFFFFF;
    step();
    chk("multu_hi", bus.exe_hi, 32'h1);
    chk("multu_lo", bus.exe_lo, 32'hFFFFFFFE);
    bus.de_mul = 1'b0;
    bus.de_double_en = 1'b0;
    bus.de_extend_rs = 33'h000000003;
    alu(4'd2, 32'h5, 32'h6, 32'hB, "add_hold");
    chk("hold_hi", bus.exe_hi, 32'h1);
    chk("hold_lo", bus.exe_lo, 32'hFFFFFFFE);
    chk("hold_double_en", bus.exe_double_en, 0);
`ifdef EXE_DIV_EN
    run_div("div_signed", 33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_zero", 33'h012345678, 33'h000000000, 32'hFFFFFFFF, 32'h12345678);
    run_div("divu", 33'h000000064, 33'h000000007, 32'h0000000E, 32'h00000002);
    bus.de_extend_rs = 33'h1FFFFFFF9;
    bus.de_extend_rt = 33'h000000002;
    bus.de_div = 1'b1;
    repeat (11) step();
    chk("mid_stall_busy", bus.exe_stall, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", bus.exe_stall, 0);
    chk("mid_rst_hi", bus.exe_hi, 0);
    chk("mid_rst_lo", bus.exe_lo, 0);
    chk("mid_rst_result", bus.exe_result, 0);
    chk("mid_rst_wdata", bus.exe_mem_wdata, 0);
    step();
    resetn = 1'b1;
    run_div("div_after_rst", 33'h1FFFFFFF9, 33'h000000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
`else
    bus.de_div = 1'b1;
    bus.de_mul = 1'b1;
    bus.de_extend_rs = 33'h1FFFFFFF9;
    bus.de_extend_rt = 33'h000000002;
    #1;
    chk("nodiv_stall", bus.exe_stall, 0);
    step();
    chk("nodiv_hi", bus.exe_hi, 0);
    chk("nodiv_lo", bus.exe_lo, 0);
    chk("nodiv_double_en", bus.exe_double_en, 1);
    chk("nodiv_reg_en", bus.exe_reg_en, 1);
    bus.de_div = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst2_result", bus.exe_result, 0);
    chk("rst2_double_en", bus.exe_double_en, 0);
    chk("rst2_wdata", bus.exe_mem_wdata, 0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_hi", bus.exe_hi, 32'hFFFFFFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
